// File: rtl/pwm_compare8.sv
// Period-aligned PWM comparator fed by a free-running N-bit counter.
// Duty updates pass through a one-entry valid/ready shadow and apply only at the counter wrap.
module pwm_compare8 #(
   parameter int unsigned N = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [N-1:0] CNT,
   input  logic         TICK,
   input  logic         EN,
   input  logic [N-1:0] DUTY,
   input  logic         DUTY_VALID,
   output logic         DUTY_READY,
   output logic         PWM,
   output logic         PERIOD_DONE,
   output logic [N-1:0] PERIODS
);

   typedef enum logic [1:0] {StOff, StArmed, StRun} state_e;

   state_e       state_q, state_d;
   logic [N-1:0] active_q, active_d;
   logic [N-1:0] pend_q, pend_d;
   logic         pend_full_q, pend_full_d;
   logic         pwm_q, pwm_d;
   logic         period_done_q, period_done_d;
   logic [N-1:0] periods_q, periods_d;
   logic         accept;

   // Reset is the only input with a combinational path to an output.
   assign DUTY_READY = !RESET && !pend_full_q;
   assign accept     = DUTY_VALID && DUTY_READY;

   always_comb begin
      active_d      = active_q;
      pend_d        = pend_q;
      pend_full_d   = pend_full_q;
      state_d       = state_q;
      periods_d     = periods_q;
      period_done_d = 1'b0;
      pwm_d         = (state_q == StRun) && (CNT < active_q);

      // Transfer needs a full shadow and accept needs an empty one, so they never collide.
      if (TICK && pend_full_q) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_d      = DUTY;
         pend_full_d = 1'b1;
      end

      unique case (state_q)
         StOff: begin
            if (EN) state_d = StArmed;
         end
         StArmed: begin
            if (!EN)       state_d = StOff;
            else if (TICK) state_d = StRun;
         end
         StRun: begin
            if (TICK) begin
               period_done_d = 1'b1;
               periods_d     = periods_q + {{(N-1){1'b0}}, 1'b1};
               if (!EN) state_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= StOff;
         active_q      <= '0;
         pend_q        <= '0;
         pend_full_q   <= 1'b0;
         pwm_q         <= 1'b0;
         period_done_q <= 1'b0;
         periods_q     <= '0;
      end else begin
         state_q       <= state_d;
         active_q      <= active_d;
         pend_q        <= pend_d;
         pend_full_q   <= pend_full_d;
         pwm_q         <= pwm_d;
         period_done_q <= period_done_d;
         periods_q     <= periods_d;
      end
   end

   assign PWM         = pwm_q;
   assign PERIOD_DONE = period_done_q;
   assign PERIODS     = periods_q;

endmodule

// File: tb/tb_pwm_compare8.sv
// Directed bench for pwm_compare8: a bench-driven counter, a table of whole-period
// measurements and hand-written handshake, enable and reset sequences.
module tb_pwm_compare8;

   logic       clk;
   logic       rst;
   logic [7:0] cnt;
   logic       tick;
   logic       en;
   logic [7:0] duty;
   logic       dv;
   logic       ready;
   logic       pwm;
   logic       pd;
   logic [7:0] periods;

   int tests;
   int failed;
   int exp_periods;

   typedef struct {
      logic       offer;
      logic [7:0] duty;
      int         exp_highs;
      logic       exp_ready1;
   } row_t;

   row_t rows[10];

   assign tick = (cnt == 8'hFF);

   pwm_compare8 #(.N(8)) dut (
      .CLK        (clk),
      .RESET      (rst),
      .CNT        (cnt),
      .TICK       (tick),
      .EN         (en),
      .DUTY       (duty),
      .DUTY_VALID (dv),
      .DUTY_READY (ready),
      .PWM        (pwm),
      .PERIOD_DONE(pd),
      .PERIODS    (periods)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock; the counter moves just after the edge like the real counter output.
   task automatic step();
      @(posedge clk);
      #1;
      cnt = cnt + 8'd1;
   endtask

   task automatic run_to(input logic [7:0] target);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (cnt != target && n < 600);
      if (cnt != target) check("run_to", {24'd0, cnt}, {24'd0, target});
   endtask

   // Starts in a CNT=0 cycle, observes CNT=1..255,0 (the samples of one whole period).
   task automatic measure(output int highs, output int first, output int last,
                          output int pds, output logic ready1);
      highs  = 0;
      first  = -1;
      last   = -1;
      pds    = 0;
      ready1 = 1'bx;
      for (int i = 0; i < 256; i++) begin
         step();
         if (i == 0) begin
            ready1 = ready;
            dv     = 1'b0;
         end
         if (pwm) begin
            highs++;
            if (first < 0) first = int'(cnt);
            last = int'(cnt);
         end
         if (pd) pds++;
      end
   endtask

   task automatic run_row(input int idx);
      int   highs, first, last, pds;
      logic ready1;
      if (rows[idx].offer) begin
         dv   = 1'b1;
         duty = rows[idx].duty;
      end
      measure(highs, first, last, pds, ready1);
      exp_periods++;
      check($sformatf("row%0d_highs", idx), highs, rows[idx].exp_highs);
      check($sformatf("row%0d_first", idx), first, (rows[idx].exp_highs == 0) ? -1 : 1);
      check($sformatf("row%0d_last", idx), last,
            (rows[idx].exp_highs == 0) ? -1 : rows[idx].exp_highs);
      check($sformatf("row%0d_pd_count", idx), pds, 1);
      check($sformatf("row%0d_pd_end", idx), {31'd0, pd}, 32'd1);
      check($sformatf("row%0d_periods", idx), {24'd0, periods}, exp_periods[7:0]);
      check($sformatf("row%0d_pwm_end", idx), {31'd0, pwm}, 32'd0);
      check($sformatf("row%0d_ready1", idx), {31'd0, ready1}, {31'd0, rows[idx].exp_ready1});
      check($sformatf("row%0d_ready_end", idx), {31'd0, ready}, 32'd1);
   endtask

   initial begin
      tests       = 0;
      failed      = 0;
      exp_periods = 0;

      rows[0] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 64,  exp_ready1: 1'b1};
      rows[1] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 64,  exp_ready1: 1'b1};
      rows[2] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 64,  exp_ready1: 1'b1};
      rows[3] = '{offer: 1'b1, duty: 8'd200, exp_highs: 32,  exp_ready1: 1'b0};
      rows[4] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 200, exp_ready1: 1'b1};
      rows[5] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 200, exp_ready1: 1'b0};
      rows[6] = '{offer: 1'b1, duty: 8'd0,   exp_highs: 10,  exp_ready1: 1'b0};
      rows[7] = '{offer: 1'b1, duty: 8'd255, exp_highs: 0,   exp_ready1: 1'b0};
      rows[8] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 255, exp_ready1: 1'b1};
      rows[9] = '{offer: 1'b0, duty: 8'd0,   exp_highs: 0,   exp_ready1: 1'b1};

      // Reset with the counter already running.
      rst  = 1'b1;
      cnt  = 8'd0;
      en   = 1'b0;
      duty = 8'd0;
      dv   = 1'b0;
      #1;
      check("ready_in_reset", {31'd0, ready}, 32'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset_state", {20'd0, pwm, pd, periods, ready}, {20'd0, 1'b0, 1'b0, 8'd0, 1'b1});

      // Idle with EN low.
      for (int i = 0; i < 300; i++) begin
         step();
         check("idle", {20'd0, pwm, pd, periods, ready}, {20'd0, 1'b0, 1'b0, 8'd0, 1'b1});
      end

      // Program 64 while off, then enable.
      run_to(8'd10);
      dv   = 1'b1;
      duty = 8'd64;
      step();
      dv = 1'b0;
      check("pend_full_off", {31'd0, ready}, 32'd0);
      en = 1'b1;
      run_to(8'd255);
      check("armed_pwm", {31'd0, pwm}, 32'd0);
      step();
      check("first_cnt0_ready", {31'd0, ready}, 32'd1);
      check("first_cnt0_pd", {31'd0, pd}, 32'd0);
      check("first_cnt0_periods", {24'd0, periods}, 32'd0);
      for (int r = 0; r < 3; r++) run_row(r);

      // Backpressure: 32 accepted mid-period, 200 held off until the shadow drains.
      run_to(8'd100);
      dv   = 1'b1;
      duty = 8'd32;
      step();
      check("bp_ready_drop", {31'd0, ready}, 32'd0);
      duty = 8'd200;
      run_to(8'd255);
      check("bp_ready_tick", {31'd0, ready}, 32'd0);
      step();
      exp_periods++;
      check("bp_ready_after_tick", {31'd0, ready}, 32'd1);
      check("bp_periods", {24'd0, periods}, exp_periods);
      run_row(3);
      run_row(4);

      // Write in the TICK cycle itself: old duty survives one more period.
      run_to(8'd255);
      dv   = 1'b1;
      duty = 8'd10;
      step();
      dv = 1'b0;
      exp_periods++;
      check("tickwr_accepted", {31'd0, ready}, 32'd0);
      check("tickwr_periods", {24'd0, periods}, exp_periods);
      for (int r = 5; r < 9; r++) run_row(r);

      // Disable mid-period: the period completes, then output stays low.
      run_to(8'd100);
      en = 1'b0;
      run_to(8'd0);
      exp_periods++;
      check("dis_pd", {31'd0, pd}, 32'd1);
      check("dis_periods", {24'd0, periods}, exp_periods);
      for (int i = 0; i < 300; i++) begin
         step();
         check("dis_quiet", {30'd0, pwm, pd}, 32'd0);
      end
      check("dis_periods_hold", {24'd0, periods}, exp_periods);

      // Re-enable, fill the shadow, then reset mid-period in RUN.
      run_to(8'd0);
      en = 1'b1;
      run_to(8'd0);
      check("armed_no_pd", {31'd0, pd}, 32'd0);
      check("armed_periods", {24'd0, periods}, exp_periods);
      run_to(8'd20);
      dv   = 1'b1;
      duty = 8'd77;
      step();
      dv = 1'b0;
      check("rst_pend_full", {31'd0, ready}, 32'd0);
      run_to(8'd50);
      check("rst_pwm_before", {31'd0, pwm}, 32'd1);
      rst  = 1'b1;
      dv   = 1'b1;
      duty = 8'd99;
      #1;
      check("rst_ready_low", {31'd0, ready}, 32'd0);
      step();
      check("rst_after", {21'd0, pwm, pd, periods}, 32'd0);
      rst = 1'b0;
      dv  = 1'b0;
      #1;
      check("rst_ready_high", {31'd0, ready}, 32'd1);
      exp_periods = 0;
      run_to(8'd0);
      check("rst_rearm_pd", {31'd0, pd}, 32'd0);
      check("rst_rearm_periods", {24'd0, periods}, 32'd0);
      run_row(9);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
